// File: rtl/wb_halt_ctrl_pkg.sv
// Shared types and constants for the writeback retirement/halt sequencer.
package wb_halt_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wb_halt_state_e;

  localparam int unsigned DRAIN_MAX_DEFAULT = 8;
  localparam int unsigned TIMER_W           = 8;

endpackage

// File: rtl/wb_halt_ctrl_if.sv
// WB-side handshake and reporting bundle for wb_halt_ctrl.
// Optional stats counters exist only when WB_STATS_EN is defined.
interface wb_halt_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             halt_req;
  logic             wb_valid;
  logic             wb_mux;
  logic             wb_halt;
  logic             fetch_stop;
  logic             halt_done;
  logic             drain_timeout;
  logic [CNT_W-1:0] retire_count;
  logic [CNT_W-1:0] cycle_count;
`ifdef WB_STATS_EN
  logic [CNT_W-1:0] alu_count;
  logic [CNT_W-1:0] mem_count;
`endif

  modport slave (
    input  halt_req, wb_valid, wb_mux, wb_halt,
    output fetch_stop, halt_done, drain_timeout, retire_count, cycle_count
`ifdef WB_STATS_EN
    , alu_count, mem_count
`endif
  );

  modport master (
    output halt_req, wb_valid, wb_mux, wb_halt,
    input  fetch_stop, halt_done, drain_timeout, retire_count, cycle_count
`ifdef WB_STATS_EN
    , alu_count, mem_count
`endif
  );

endinterface

// File: rtl/wb_halt_ctrl_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_halt_ctrl.sv
// Halt sequencer beside WB: stops fetch on HALT, drains, flags completion.
// Define WB_STATS_EN to add the ALU/memory retirement split counters.
module wb_halt_ctrl
  import wb_halt_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_halt_ctrl_if.slave  bus
);

  wb_halt_state_e     state;
  logic [TIMER_W-1:0] timer;
  logic               fetch_stop_q;
  logic               halt_done_q;
  logic               drain_timeout_q;
  logic               active;
  logic               halt_retire;
  logic               retire_en;
  logic [CNT_W-1:0]   retire_q;
  logic [CNT_W-1:0]   cycle_q;

  assign active      = (state != DONE);
  assign halt_retire = bus.wb_valid & bus.wb_halt;
  assign retire_en   = active & bus.wb_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      timer           <= '0;
      fetch_stop_q    <= 1'b0;
      halt_done_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_retire) begin
            state           <= DONE;
            fetch_stop_q    <= 1'b1;
            halt_done_q     <= 1'b1;
            drain_timeout_q <= 1'b0;
          end else if (bus.halt_req) begin
            state        <= DRAIN;
            fetch_stop_q <= 1'b1;
            timer        <= '0;
          end
        end
        DRAIN: begin
          timer <= timer + 1'b1;
          // A HALT retiring on the final timer cycle is a clean finish.
          if (halt_retire) begin
            state           <= DONE;
            halt_done_q     <= 1'b1;
            drain_timeout_q <= 1'b0;
          end else if (timer == TIMER_W'(DRAIN_MAX - 1)) begin
            state           <= DONE;
            halt_done_q     <= 1'b1;
            drain_timeout_q <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire_en),
    .clr   (1'b0),
    .q     (retire_q)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (active),
    .clr   (1'b0),
    .q     (cycle_q)
  );

  assign bus.fetch_stop    = fetch_stop_q;
  assign bus.halt_done     = halt_done_q;
  assign bus.drain_timeout = drain_timeout_q;
  assign bus.retire_count  = retire_q;
  assign bus.cycle_count   = cycle_q;

`ifdef WB_STATS_EN
  logic [CNT_W-1:0] alu_q;
  logic [CNT_W-1:0] mem_q;

  sat_counter #(.W(CNT_W)) u_alu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire_en & bus.wb_mux),
    .clr   (1'b0),
    .q     (alu_q)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire_en & ~bus.wb_mux),
    .clr   (1'b0),
    .q     (mem_q)
  );

  assign bus.alu_count = alu_q;
  assign bus.mem_count = mem_q;
`else
  logic unused_wb_mux;
  assign unused_wb_mux = bus.wb_mux;
`endif

endmodule
